ram_burst_dp: RTL and testbench

// - Unified instruction/data memory for the single-cycle RISC-V core: one array of WIDTH-bit words.
// - Two independent BURST-word windows:
//   - instruction fetch port (read-only);
//   - data port (read/write).
// - Addresses are halfword-granular (byte address >> 1). A 32-bit RVC fetch may start on any
//   16-bit boundary, and a burst access returns BURST consecutive words.

---
 rtl/ram_burst_dp_pkg.sv | 18 +
 rtl/ram_words_core.sv | 51 +++++
 rtl/ram_burst_dp.sv | 63 ++++++
 tb/tb_ram_burst_dp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_dp_pkg.sv
// Shared constants and the burst index helper for the unified
// instruction/data memory.
package ram_burst_dp_pkg;

   // Natural word size of the array (one RVC parcel).
   localparam int WORD_W = 16;

   // Index of word k of a burst starting at addr.
   // depth must be a power of two. Bursts wrap from depth-1 back to 0.
   function automatic logic [31:0] burst_idx(input logic [31:0] addr,
                                             input int unsigned k,
                                             input int unsigned depth);
      logic [31:0] mask;
      mask = depth - 1;
      return (addr + k) & mask;
   endfunction

endpackage

// File: rtl/ram_words_core.sv
// Word array with two asynchronous BURST-word read ports and one synchronous
// BURST-word write port. The array is never cleared, so a preloaded image
// survives reset. Tooling reaches the storage as mem_inst.words.
module ram_words_core
   import ram_burst_dp_pkg::*;
#(
   parameter int DEPTH = 1048576,
   parameter int WIDTH = WORD_W,
   parameter int BURST = 2,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        write_en,
   input  logic [IW-1:0]               iaddr,
   input  logic [IW-1:0]               daddr,
   input  logic [BURST-1:0][WIDTH-1:0] wdata,
   output logic [BURST-1:0][WIDTH-1:0] irdata,
   output logic [BURST-1:0][WIDTH-1:0] drdata
);

   logic [WIDTH-1:0] words [0:DEPTH-1];

   logic [IW-1:0] i_idx [BURST];
   logic [IW-1:0] d_idx [BURST];
   logic          we_gated;

   // Per-word wrapped indices and combinational read-out for both ports.
   for (genvar gi = 0; gi < BURST; gi++) begin : g_port
      assign i_idx[gi]  = IW'(burst_idx(32'(iaddr), gi, DEPTH));
      assign d_idx[gi]  = IW'(burst_idx(32'(daddr), gi, DEPTH));
      assign irdata[gi] = words[i_idx[gi]];
      assign drdata[gi] = words[d_idx[gi]];
   end

   // Reset blocks stores at once, without waiting for a clock edge.
   always_comb begin
      we_gated = write_en & ~reset;
   end

   // Store all BURST words at the rising edge. Reads see the new data only
   // after the edge.
   always_ff @(posedge clock) begin
      if (we_gated) begin
         for (int k = 0; k < BURST; k++) begin
            words[d_idx[k]] <= wdata[k];
         end
      end
   end

endmodule

// File: rtl/ram_burst_dp.sv
// Unified instruction/data memory for the single-cycle RISC-V core.
// Halfword-granular addresses. A fetch port and a data port each see a
// BURST-word window with no alignment restriction. Address bits above
// log2(DEPTH) are ignored, so the memory aliases.
module ram_burst_dp
   import ram_burst_dp_pkg::*;
#(
   parameter int DEPTH = 1048576,
   parameter int WIDTH = WORD_W,
   parameter int BURST = 2,
   parameter int AW    = 31
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   write_en,
   input  logic [AW-1:0]          iaddr,
   input  logic [AW-1:0]          daddr,
   input  logic [WIDTH*BURST-1:0] data_i,
   output logic [WIDTH*BURST-1:0] data_o,
   output logic [WIDTH*BURST-1:0] inst_o
);

   localparam int IW = $clog2(DEPTH);

   logic [IW-1:0]               iaddr_lo;
   logic [IW-1:0]               daddr_lo;
   logic [BURST-1:0][WIDTH-1:0] wdata;
   logic [BURST-1:0][WIDTH-1:0] irdata;
   logic [BURST-1:0][WIDTH-1:0] drdata;

   // Keep only the bits that index the array.
   assign iaddr_lo = iaddr[IW-1:0];
   assign daddr_lo = daddr[IW-1:0];

   // The upper address bits are deliberately dropped. This causes the aliasing.
   if (AW > IW) begin : g_alias
      logic unused_hi_bits;
      assign unused_hi_bits = ^{iaddr[AW-1:IW], daddr[AW-1:IW]};
   end

   // Word k of each bus occupies bits [k*WIDTH +: WIDTH], so word 0 is in the LSBs.
   for (genvar gi = 0; gi < BURST; gi++) begin : g_pack
      assign wdata[gi]                  = data_i[gi*WIDTH +: WIDTH];
      assign data_o[gi*WIDTH +: WIDTH]  = drdata[gi];
      assign inst_o[gi*WIDTH +: WIDTH]  = irdata[gi];
   end

   ram_words_core #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .BURST (BURST)
   ) mem_inst (
      .clock    (clock),
      .reset    (reset),
      .write_en (write_en),
      .iaddr    (iaddr_lo),
      .daddr    (daddr_lo),
      .wdata    (wdata),
      .irdata   (irdata),
      .drdata   (drdata)
   );

endmodule

// File: tb/tb_ram_burst_dp.sv
// Directed and randomized checks of ram_burst_dp against an array model.
// The main instance is the RV32 build. A second, small RV64 build
// (BURST=4) is also instantiated.
module tb_ram_burst_dp;

   localparam int DEPTH  = 1048576;
   localparam int WIDTH  = 16;
   localparam int BURST  = 2;
   localparam int AW     = 31;
   localparam int DW     = WIDTH * BURST;
   localparam int DEPTH4 = 256;
   localparam int BURST4 = 4;
   localparam int DW4    = WIDTH * BURST4;

   logic          clock    = 1'b0;
   logic          reset    = 1'b1;
   logic          write_en = 1'b0;
   logic [AW-1:0] iaddr    = '0;
   logic [AW-1:0] daddr    = '0;
   logic [DW-1:0] data_i   = '0;
   logic [DW-1:0] data_o;
   logic [DW-1:0] inst_o;

   logic           write_en4 = 1'b0;
   logic [AW-1:0]  iaddr4    = '0;
   logic [AW-1:0]  daddr4    = '0;
   logic [DW4-1:0] data_i4   = '0;
   logic [DW4-1:0] data_o4;
   logic [DW4-1:0] inst_o4;

   int checks = 0;
   int errors = 0;

   // Reference contents: word index -> value (only for words the bench wrote).
   logic [WIDTH-1:0] mdl  [int];
   logic [WIDTH-1:0] mdl4 [int];

   ram_burst_dp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BURST(BURST), .AW(AW)) dut (
      .clock    (clock),
      .reset    (reset),
      .write_en (write_en),
      .iaddr    (iaddr),
      .daddr    (daddr),
      .data_i   (data_i),
      .data_o   (data_o),
      .inst_o   (inst_o)
   );

   ram_burst_dp #(.DEPTH(DEPTH4), .WIDTH(WIDTH), .BURST(BURST4), .AW(AW)) dut4 (
      .clock    (clock),
      .reset    (reset),
      .write_en (write_en4),
      .iaddr    (iaddr4),
      .daddr    (daddr4),
      .data_i   (data_i4),
      .data_o   (data_o4),
      .inst_o   (inst_o4)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Burst read from the model: word k comes from (a + k) mod depth.
   function automatic logic [63:0] mdl_rd(input longint unsigned a, input bit four);
      logic [63:0] r;
      int          n;
      longint unsigned dep;
      r   = '0;
      n   = four ? BURST4 : BURST;
      dep = four ? longint'(DEPTH4) : longint'(DEPTH);
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = int'((a + longint'(k)) % dep);
         if (four) r[k*WIDTH +: WIDTH] = mdl4.exists(idx) ? mdl4[idx] : '0;
         else      r[k*WIDTH +: WIDTH] = mdl.exists(idx)  ? mdl[idx]  : '0;
      end
      return r;
   endfunction

   task automatic mdl_wr(input longint unsigned a, input logic [63:0] d, input bit four);
      int n;
      n = four ? BURST4 : BURST;
      for (int k = 0; k < n; k++) begin
         if (four) mdl4[int'((a + longint'(k)) % longint'(DEPTH4))] = d[k*WIDTH +: WIDTH];
         else      mdl[int'((a + longint'(k)) % longint'(DEPTH))]   = d[k*WIDTH +: WIDTH];
      end
   endtask

   // One write cycle on the RV32 instance.
   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      daddr    = a;
      data_i   = d;
      write_en = 1'b1;
      @(posedge clock);
      #1;
      write_en = 1'b0;
      mdl_wr(longint'(a), 64'(d), 1'b0);
      $display("wr32 addr=0x%0h data=0x%0h", a, d);
   endtask

   // One write cycle on the RV64 instance.
   task automatic wr4(input logic [AW-1:0] a, input logic [DW4-1:0] d);
      @(negedge clock);
      daddr4    = a;
      data_i4   = d;
      write_en4 = 1'b1;
      @(posedge clock);
      #1;
      write_en4 = 1'b0;
      mdl_wr(longint'(a), d, 1'b1);
      $display("wr64 addr=0x%0h data=0x%0h", a, d);
   endtask

   initial begin
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] d;

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Aligned write, then aligned and misaligned data reads.
      wr(31'h12, 32'h5A5AC3C3);
      wr(31'h10, 32'hDEADBEEF);
      @(negedge clock);
      daddr = 31'h10;
      #1;
      check("aligned_rd", 64'(data_o), 64'h0000_0000_DEAD_BEEF);
      check("w10", 64'(dut.mem_inst.words[32'h10]), 64'hBEEF);
      check("w11", 64'(dut.mem_inst.words[32'h11]), 64'hDEAD);
      daddr = 31'h11;
      #1;
      check("misaligned_rd_lo", 64'(data_o[15:0]), 64'hDEAD);
      check("misaligned_rd", 64'(data_o), mdl_rd(64'h11, 1'b0));
      $display("rd32 daddr=0x11 data=0x%0h", data_o);

      // Misaligned instruction fetch, visible in the same cycle.
      wr(31'h20, 32'h22221111);
      wr(31'h22, 32'h44443333);
      @(negedge clock);
      iaddr = 31'h21;
      #1;
      check("fetch_misaligned", 64'(inst_o), 64'h3333_2222);
      $display("rd32 iaddr=0x21 inst=0x%0h", inst_o);

      // Wrap at the top of the array, plus aliasing on both ports.
      wr(31'h5, 32'h76543210);
      wr(31'(DEPTH - 1), 32'hAAAA5555);
      check("wrap_top", 64'(dut.mem_inst.words[DEPTH-1]), 64'h5555);
      check("wrap_zero", 64'(dut.mem_inst.words[0]), 64'hAAAA);
      @(negedge clock);
      iaddr = 31'(DEPTH - 1);
      #1;
      check("wrap_fetch", 64'(inst_o), 64'hAAAA_5555);
      iaddr = 31'(DEPTH + 5);
      #1;
      check("alias_fetch", 64'(inst_o), 64'h7654_3210);
      wr(31'h4000_0030, 32'h0BADCAFE);
      check("alias_wr_lo", 64'(dut.mem_inst.words[32'h30]), 64'hCAFE);
      check("alias_wr_hi", 64'(dut.mem_inst.words[32'h31]), 64'h0BAD);

      // Read-during-write with both ports on the written window.
      wr(31'h40, 32'h12345678);
      @(negedge clock);
      iaddr    = 31'h40;
      daddr    = 31'h40;
      data_i   = 32'hCAFEF00D;
      write_en = 1'b1;
      #1;
      check("rdw_pre_data", 64'(data_o), 64'h1234_5678);
      check("rdw_pre_inst", 64'(inst_o), 64'h1234_5678);
      @(posedge clock);
      #1;
      write_en = 1'b0;
      mdl_wr(64'h40, 64'h0000_0000_CAFE_F00D, 1'b0);
      check("rdw_post_data", 64'(data_o), 64'hCAFE_F00D);
      check("rdw_post_inst", 64'(inst_o), 64'hCAFE_F00D);
      $display("rdw addr=0x40 data=0x%0h inst=0x%0h", data_o, inst_o);

      // Reset raised mid-cycle while a write is pending: the write must not happen.
      wr(31'h8, 32'h000000AB);
      @(negedge clock);
      daddr    = 31'h8;
      iaddr    = 31'h8;
      data_i   = 32'hFFFFFFFF;
      write_en = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("rst_data_o", 64'(data_o), 64'h0000_00AB);
      check("rst_inst_o", 64'(inst_o), 64'h0000_00AB);
      @(posedge clock);
      #1;
      check("rst_no_write", 64'(dut.mem_inst.words[8]), 64'h00AB);
      check("rst_data_hold", 64'(data_o), 64'h0000_00AB);
      @(negedge clock);
      reset    = 1'b0;
      write_en = 1'b0;
      $display("reset window done addr=0x8 data=0x%0h", data_o);
      wr(31'h8, 32'h5678_12CD);
      check("post_rst_write", 64'(data_o), 64'h5678_12CD);
      check("post_rst_w9", 64'(dut.mem_inst.words[9]), 64'h5678);

      // Randomized traffic in a pre-filled window, checked on both ports around each edge.
      for (int a = 32'h100; a < 32'h142; a += 2) wr(31'(a), $urandom);
      for (int i = 0; i < 40; i++) begin
         wa = 31'(32'h100 + $urandom_range(0, 63));
         ra = 31'(32'h100 + $urandom_range(0, 63));
         d  = $urandom;
         @(negedge clock);
         daddr    = wa;
         iaddr    = ra;
         data_i   = d;
         write_en = 1'b1;
         #1;
         check("rnd_pre_data", 64'(data_o), mdl_rd(longint'(wa), 1'b0));
         check("rnd_pre_inst", 64'(inst_o), mdl_rd(longint'(ra), 1'b0));
         @(posedge clock);
         #1;
         write_en = 1'b0;
         mdl_wr(longint'(wa), 64'(d), 1'b0);
         check("rnd_post_data", 64'(data_o), mdl_rd(longint'(wa), 1'b0));
         check("rnd_post_inst", 64'(inst_o), mdl_rd(longint'(ra), 1'b0));
         $display("rnd%0d wa=0x%0h d=0x%0h ra=0x%0h inst=0x%0h", i, wa, d, ra, inst_o);
      end

      // RV64 build: 4-word bursts, including the wrap.
      wr4(31'h3, 64'h0123456789ABCDEF);
      check("b4_w3", 64'(dut4.mem_inst.words[3]), 64'hCDEF);
      check("b4_w4", 64'(dut4.mem_inst.words[4]), 64'h89AB);
      check("b4_w5", 64'(dut4.mem_inst.words[5]), 64'h4567);
      check("b4_w6", 64'(dut4.mem_inst.words[6]), 64'h0123);
      @(negedge clock);
      daddr4 = 31'h3;
      #1;
      check("b4_data_o", data_o4, 64'h0123456789ABCDEF);
      wr4(31'(DEPTH4 - 2), {$urandom, $urandom});
      @(negedge clock);
      iaddr4 = 31'(DEPTH4 - 2);
      #1;
      check("b4_wrap_fetch", inst_o4, mdl_rd(longint'(DEPTH4 - 2), 1'b1));
      check("b4_wrap_w0", 64'(dut4.mem_inst.words[0]), 64'(mdl4[0]));
      $display("rd64 iaddr=0x%0h inst=0x%0h", iaddr4, inst_o4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
